// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Brief    : Hazard-to-control arbiter for a 5-stage MIPS pipeline with MDU
//            interlock tracking and saturating stall/flush counters.
// Revision : 1.0
// ============================================================================
module pipeline_stall_ctrl #(
    parameter int MDU_LAT = 32,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken_id,
    input  logic             mdu_start_ex,
    input  logic             mdu_use_id,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Write,
    output logic             MEMWB_Write,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int c_MDU_CW = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
    localparam logic [c_MDU_CW-1:0] c_MDU_LOAD = c_MDU_CW'(MDU_LAT - 1);
    localparam logic [CNT_W-1:0]    c_CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_MDU_CW-1:0] r_mduCnt;
    logic [CNT_W-1:0]    r_stallCycles;
    logic [CNT_W-1:0]    r_flushCount;

    logic w_memFreeze;
    logic w_hazard;
    logic w_mduAccept;

    assign mdu_busy    = (r_state == MDU_BUSY);
    assign w_memFreeze = dmem_req_mem & ~dmem_ready;
    assign w_hazard    = stall | (mdu_use_id & mdu_busy);
    // A frozen pipeline cannot hand a new op to the MDU.
    assign w_mduAccept = mdu_start_ex & ~w_memFreeze;

    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEX_Bubble = 1'b0;
        EXMEM_Write = 1'b1;
        MEMWB_Write = 1'b1;
        if (reset) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            EXMEM_Write = 1'b0;
            MEMWB_Write = 1'b0;
        end else if (w_memFreeze) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            EXMEM_Write = 1'b0;
            MEMWB_Write = 1'b0;
        end else if (w_hazard) begin
            // Branch is ignored here: its operands are not yet resolved.
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
        end else if (branch_taken_id) begin
            IFID_Flush  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= RUN;
            r_mduCnt <= '0;
        end else if (w_mduAccept) begin
            r_state  <= MDU_BUSY;
            r_mduCnt <= c_MDU_LOAD;
        end else if (r_state == MDU_BUSY) begin
            if (r_mduCnt == '0) begin
                r_state <= RUN;
            end else begin
                r_mduCnt <= r_mduCnt - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (!PC_Write && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + c_CNT_ONE;
            end
            if (IFID_Flush && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + c_CNT_ONE;
            end
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_count  = r_flushCount;

endmodule
`default_nettype wire
